// File: rtl/mem_store_align.sv
// =============================================================================
// Module  : mem_store_align
// Brief   : Store lane alignment; splits boundary-crossing stores into two beats
// Revision: 1.0
// =============================================================================
`default_nettype none

module mem_store_align #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         st_valid,
   output logic         st_ready,
   input  logic [N-1:0] st_addr,
   input  logic [N-1:0] st_data,
   input  logic [2:0]   st_width,
   output logic         dm_wen,
   input  logic         dm_ready,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   output logic [7:0]   dm_byteEn,
   output logic         st_done,
   output logic         st_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

   localparam logic [N-1:0] c_BEAT_STRIDE = N'(8);

   state_t         r_state;
   logic [N-1:0]   r_hi_data;
   logic [7:0]     r_hi_be;
   logic           r_split;
   logic           r_dm_wen;
   logic [N-1:0]   r_dm_addr;
   logic [N-1:0]   r_dm_wdata;
   logic [7:0]     r_dm_be;
   logic           r_done;
   logic           r_err;

   logic [2:0]     w_offset;
   logic [5:0]     w_shift;
   logic [N-1:0]   w_base;
   logic [7:0]     w_mask8;
   logic [15:0]    w_be16;
   logic [N-1:0]   w_data_mask;
   logic [N-1:0]   w_data_clean;
   logic [2*N-1:0] w_d128;
   logic           w_split;
   logic           w_legal;

   assign w_offset = st_addr[2:0];
   assign w_shift  = {w_offset, 3'b000};
   assign w_base   = {st_addr[N-1:3], 3'b000};
   assign w_mask8  = {{4{st_width[2]}}, {2{st_width[1]}}, st_width[0], 1'b1};
   assign w_be16   = {8'b0, w_mask8} << w_offset;
   assign w_split  = |w_be16[15:8];
   assign w_legal  = (st_width == 3'b000) || (st_width == 3'b001) ||
                     (st_width == 3'b011) || (st_width == 3'b111);

   // Bytes beyond the store width are zeroed so disabled lanes carry no stale data
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane_mask
      assign w_data_mask[8*gi +: 8] = {8{w_mask8[gi]}};
   end

   assign w_data_clean = st_data & w_data_mask;
   assign w_d128       = {{N{1'b0}}, w_data_clean} << w_shift;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_hi_data  <= '0;
         r_hi_be    <= '0;
         r_split    <= 1'b0;
         r_dm_wen   <= 1'b0;
         r_dm_addr  <= '0;
         r_dm_wdata <= '0;
         r_dm_be    <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (st_valid) begin
                  if (w_legal) begin
                     r_state    <= BEAT0;
                     r_split    <= w_split;
                     r_hi_data  <= w_d128[2*N-1:N];
                     r_hi_be    <= w_be16[15:8];
                     r_dm_wen   <= 1'b1;
                     r_dm_addr  <= w_base;
                     r_dm_wdata <= w_d128[N-1:0];
                     r_dm_be    <= w_be16[7:0];
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            BEAT0: begin
               if (dm_ready) begin
                  if (r_split) begin
                     r_state    <= BEAT1;
                     r_dm_addr  <= r_dm_addr + c_BEAT_STRIDE;
                     r_dm_wdata <= r_hi_data;
                     r_dm_be    <= r_hi_be;
                  end else begin
                     r_state    <= IDLE;
                     r_dm_wen   <= 1'b0;
                     r_dm_wdata <= '0;
                     r_dm_be    <= '0;
                     r_done     <= 1'b1;
                  end
               end
            end
            BEAT1: begin
               if (dm_ready) begin
                  r_state    <= IDLE;
                  r_dm_wen   <= 1'b0;
                  r_dm_wdata <= '0;
                  r_dm_be    <= '0;
                  r_done     <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign st_ready  = (r_state == IDLE);
   assign dm_wen    = r_dm_wen;
   assign dm_addr   = r_dm_addr;
   assign dm_wdata  = r_dm_wdata;
   assign dm_byteEn = r_dm_be;
   assign st_done   = r_done;
   assign st_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_align.sv
// =============================================================================
// Module  : tb_mem_store_align
// Brief   : Directed self-checking bench for mem_store_align
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_mem_store_align;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   logic [2:0]  st_width;
   logic        dm_wen;
   logic        dm_ready;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic [7:0]  dm_byteEn;
   logic        st_done;
   logic        st_err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_store_align #(.N(64)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_width  (st_width),
      .dm_wen    (dm_wen),
      .dm_ready  (dm_ready),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_byteEn (dm_byteEn),
      .st_done   (st_done),
      .st_err    (st_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single edge; DUT must be in IDLE on entry
   task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [2:0] w);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_width = w;
      step();
      st_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      st_valid = 1'b0;
      dm_ready = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_width = '0;
      step();
      step();
      n_total++; if (st_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", st_ready); else n_pass++;
      n_total++; if (dm_wen !== 1'b0) $display("FAIL rst_wen got %b exp 0", dm_wen); else n_pass++;
      n_total++; if (dm_addr !== 64'h0) $display("FAIL rst_addr got %h exp 0", dm_addr); else n_pass++;
      n_total++; if (dm_wdata !== 64'h0) $display("FAIL rst_wdata got %h exp 0", dm_wdata); else n_pass++;
      n_total++; if (dm_byteEn !== 8'h00) $display("FAIL rst_be got %h exp 00", dm_byteEn); else n_pass++;
      n_total++; if ({st_done, st_err} !== 2'b00) $display("FAIL rst_pulses got %b exp 00", {st_done, st_err}); else n_pass++;
      reset = 1'b1;
      step();
   endtask

   task automatic test_byte();
      dm_ready = 1'b1;
      issue(64'h1003, 64'hDEAD_BEEF_CAFE_12AB, 3'b000);
      n_total++; if (dm_wen !== 1'b1) $display("FAIL sb_wen got %b exp 1", dm_wen); else n_pass++;
      n_total++; if (dm_addr !== 64'h1000) $display("FAIL sb_addr got %h exp 1000", dm_addr); else n_pass++;
      n_total++; if (dm_byteEn !== 8'h08) $display("FAIL sb_be got %h exp 08", dm_byteEn); else n_pass++;
      n_total++; if (dm_wdata !== 64'h0000_0000_AB00_0000) $display("FAIL sb_wdata got %h exp 00000000ab000000", dm_wdata); else n_pass++;
      n_total++; if (st_ready !== 1'b0) $display("FAIL sb_busy got %b exp 0", st_ready); else n_pass++;
      step();
      n_total++; if (st_done !== 1'b1) $display("FAIL sb_done got %b exp 1", st_done); else n_pass++;
      n_total++; if (dm_wen !== 1'b0) $display("FAIL sb_wen_off got %b exp 0", dm_wen); else n_pass++;
      n_total++; if ({dm_byteEn, dm_wdata} !== 72'h0) $display("FAIL sb_idle_zero got be %h wdata %h exp 0", dm_byteEn, dm_wdata); else n_pass++;
      n_total++; if (dm_addr !== 64'h1000) $display("FAIL sb_addr_hold got %h exp 1000", dm_addr); else n_pass++;
      step();
      n_total++; if (st_done !== 1'b0) $display("FAIL sb_done_pulse got %b exp 0", st_done); else n_pass++;
   endtask

   task automatic test_split();
      dm_ready = 1'b1;
      issue(64'h2006, 64'hFFFF_FFFF_1122_3344, 3'b011);
      n_total++; if (dm_addr !== 64'h2000) $display("FAIL sw_b0_addr got %h exp 2000", dm_addr); else n_pass++;
      n_total++; if (dm_byteEn !== 8'hC0) $display("FAIL sw_b0_be got %h exp c0", dm_byteEn); else n_pass++;
      n_total++; if (dm_wdata !== 64'h3344_0000_0000_0000) $display("FAIL sw_b0_wdata got %h exp 3344000000000000", dm_wdata); else n_pass++;
      step();
      n_total++; if (dm_wen !== 1'b1) $display("FAIL sw_b1_wen got %b exp 1", dm_wen); else n_pass++;
      n_total++; if (dm_addr !== 64'h2008) $display("FAIL sw_b1_addr got %h exp 2008", dm_addr); else n_pass++;
      n_total++; if (dm_byteEn !== 8'h03) $display("FAIL sw_b1_be got %h exp 03", dm_byteEn); else n_pass++;
      n_total++; if (dm_wdata !== 64'h0000_0000_0000_1122) $display("FAIL sw_b1_wdata got %h exp 1122", dm_wdata); else n_pass++;
      n_total++; if (st_done !== 1'b0) $display("FAIL sw_early_done got %b exp 0", st_done); else n_pass++;
      step();
      n_total++; if ({st_done, dm_wen} !== 2'b10) $display("FAIL sw_done got done,wen %b exp 10", {st_done, dm_wen}); else n_pass++;
      step();
   endtask

   task automatic test_stall();
      dm_ready = 1'b0;
      issue(64'h3000, 64'h0123_4567_89AB_CDEF, 3'b111);
      for (int i = 0; i < 4; i++) begin
         n_total++; if (dm_wen !== 1'b1) $display("FAIL sd_wen[%0d] got %b exp 1", i, dm_wen); else n_pass++;
         n_total++; if ({dm_addr, dm_wdata, dm_byteEn} !== {64'h3000, 64'h0123_4567_89AB_CDEF, 8'hFF})
            $display("FAIL sd_hold[%0d] got addr %h wdata %h be %h exp 3000 0123456789abcdef ff", i, dm_addr, dm_wdata, dm_byteEn);
         else n_pass++;
         n_total++; if (st_done !== 1'b0) $display("FAIL sd_early_done[%0d] got %b exp 0", i, st_done); else n_pass++;
         if (i == 3) dm_ready = 1'b1;
         step();
      end
      n_total++; if ({st_done, dm_wen} !== 2'b10) $display("FAIL sd_done got done,wen %b exp 10", {st_done, dm_wen}); else n_pass++;
      step();
   endtask

   task automatic test_illegal();
      dm_ready = 1'b1;
      issue(64'h4000, 64'h1234, 3'b010);
      n_total++; if (st_err !== 1'b1) $display("FAIL ill_err got %b exp 1", st_err); else n_pass++;
      n_total++; if (dm_wen !== 1'b0) $display("FAIL ill_wen got %b exp 0", dm_wen); else n_pass++;
      n_total++; if (st_ready !== 1'b1) $display("FAIL ill_ready got %b exp 1", st_ready); else n_pass++;
      n_total++; if (st_done !== 1'b0) $display("FAIL ill_done got %b exp 0", st_done); else n_pass++;
      step();
      n_total++; if ({st_err, dm_wen} !== 2'b00) $display("FAIL ill_pulse got err,wen %b exp 00", {st_err, dm_wen}); else n_pass++;
      issue(64'h4000, 64'h1234, 3'b101);
      n_total++; if ({st_err, dm_wen} !== 2'b10) $display("FAIL ill101 got err,wen %b exp 10", {st_err, dm_wen}); else n_pass++;
      step();
   endtask

   task automatic test_wrap();
      dm_ready = 1'b1;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_BEEF, 3'b001);
      n_total++; if (dm_addr !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL wr_b0_addr got %h exp fffffffffffffff8", dm_addr); else n_pass++;
      n_total++; if (dm_byteEn !== 8'h80) $display("FAIL wr_b0_be got %h exp 80", dm_byteEn); else n_pass++;
      n_total++; if (dm_wdata !== 64'hEF00_0000_0000_0000) $display("FAIL wr_b0_wdata got %h exp ef00000000000000", dm_wdata); else n_pass++;
      step();
      n_total++; if (dm_addr !== 64'h0) $display("FAIL wr_b1_addr got %h exp 0", dm_addr); else n_pass++;
      n_total++; if (dm_byteEn !== 8'h01) $display("FAIL wr_b1_be got %h exp 01", dm_byteEn); else n_pass++;
      n_total++; if (dm_wdata !== 64'h0000_0000_0000_00BE) $display("FAIL wr_b1_wdata got %h exp be", dm_wdata); else n_pass++;
      step();
      n_total++; if (st_done !== 1'b1) $display("FAIL wr_done got %b exp 1", st_done); else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      dm_ready = 1'b1;
      issue(64'h10, 64'hFF55, 3'b000);
      n_total++; if ({dm_addr, dm_byteEn, dm_wdata} !== {64'h10, 8'h01, 64'h55})
         $display("FAIL b2b_first got addr %h be %h wdata %h exp 10 01 55", dm_addr, dm_byteEn, dm_wdata);
      else n_pass++;
      st_valid = 1'b1;
      st_addr  = 64'h1A;
      st_data  = 64'hFFFF_7766;
      st_width = 3'b001;
      step();
      n_total++; if ({st_done, st_ready} !== 2'b11) $display("FAIL b2b_done_ready got %b exp 11", {st_done, st_ready}); else n_pass++;
      step();
      st_valid = 1'b0;
      n_total++; if ({dm_wen, dm_addr, dm_byteEn, dm_wdata} !== {1'b1, 64'h18, 8'h0C, 64'h7766_0000})
         $display("FAIL b2b_second got wen %b addr %h be %h wdata %h exp 1 18 0c 77660000", dm_wen, dm_addr, dm_byteEn, dm_wdata);
      else n_pass++;
      step();
      n_total++; if (st_done !== 1'b1) $display("FAIL b2b_done2 got %b exp 1", st_done); else n_pass++;
      step();
   endtask

   task automatic test_reset_midstore();
      dm_ready = 1'b0;
      issue(64'h2006, 64'h1122_3344, 3'b011);
      dm_ready = 1'b1;
      step();
      dm_ready = 1'b0;
      n_total++; if ({dm_wen, dm_addr} !== {1'b1, 64'h2008}) $display("FAIL rm_b1 got wen %b addr %h exp 1 2008", dm_wen, dm_addr); else n_pass++;
      step();
      reset = 1'b0;
      step();
      n_total++; if ({dm_wen, dm_addr, dm_wdata, dm_byteEn} !== 137'h0)
         $display("FAIL rm_outs got wen %b addr %h wdata %h be %h exp 0", dm_wen, dm_addr, dm_wdata, dm_byteEn);
      else n_pass++;
      n_total++; if ({st_ready, st_done, st_err} !== 3'b100) $display("FAIL rm_ctl got ready,done,err %b exp 100", {st_ready, st_done, st_err}); else n_pass++;
      reset = 1'b1;
      dm_ready = 1'b1;
      step();
      n_total++; if ({st_done, dm_wen, st_ready} !== 3'b001) $display("FAIL rm_after got done,wen,ready %b exp 001", {st_done, dm_wen, st_ready}); else n_pass++;
      step();
      n_total++; if ({st_done, dm_wen} !== 2'b00) $display("FAIL rm_after2 got done,wen %b exp 00", {st_done, dm_wen}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_byte();
      test_split();
      test_stall();
      test_illegal();
      test_wrap();
      test_back_to_back();
      test_reset_midstore();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
